// File: rtl/imem_fetch_pkg.sv
// Shared types for the instruction fetch controller and its prefetch queue.
// Holds the FSM encoding, the queued {pc, word} entry and the default start address.
package imem_fetch_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch queue of {pc, word} entries with a single-cycle flush.
// The head entry reads as zero whenever the queue is empty.
module fetch_fifo
    import imem_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   r_mem [DEPTH];
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [CW-1:0]  r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (pop) begin
                r_head <= r_head + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            r_mem[r_tail] <= push_data;
        end
    end

    assign head  = (r_count != '0) ? r_mem[r_head] : '0;
    assign count = r_count;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: drives the fetch PC, fills the prefetch queue
// and hands instructions to decode over a valid/ready handshake.
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] fetch_count
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   w_pc_nxt;
    logic [31:0]   r_fetch_count;
    logic          w_push;
    logic          w_pop;
    logic          w_room;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_data;

    assign w_pop       = inst_valid && inst_ready;
    assign w_room      = (w_count < CW'(DEPTH)) || w_pop;
    assign w_push_data = '{pc: r_fetch_pc, word: imem_data};

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_fetch_pc;
        w_push      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (fetch_en) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fetch_en && w_room) begin
                    w_push   = 1'b1;
                    w_pc_nxt = r_fetch_pc + 32'd4;
                end
            end
        endcase
        // A redirect overrides any fetch decided above.
        if (redirect) begin
            w_state_nxt = ST_RUN;
            w_pc_nxt    = word_align(redirect_pc);
            w_push      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_fetch_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_pc_nxt;
            if (w_pop) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count)
    );

    assign imem_addr   = r_fetch_pc;
    assign inst_valid  = (w_count != '0);
    assign inst        = w_head.word;
    assign inst_pc     = w_head.pc;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed vector table, then randomized traffic
// compared against a queue-based reference model.
module tb_imem_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] fetch_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_data = mem_fn(imem_addr);

    imem_fetch_ctrl #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .fetch_count (fetch_count)
    );

    // Reference model: the queue holds {pc, word}; it follows the
    // textual rules for push, pop, redirect and reset.
    logic [63:0] mq[$];
    logic [31:0] mpc;
    logic        mrun;
    logic [31:0] mfc;

    task automatic model_edge(input logic r, input logic fe, input logic red,
                              input logic [31:0] rp, input logic rdy);
        logic popd;
        if (r) begin
            mq.delete();
            mpc  = RST_PC;
            mrun = 1'b0;
            mfc  = 32'd0;
        end else begin
            popd = (mq.size() != 0) && rdy;
            if (popd) begin
                mfc = mfc + 32'd1;
                void'(mq.pop_front());
            end
            if (red) begin
                mq.delete();
                mpc  = {rp[31:2], 2'b00};
                mrun = 1'b1;
            end else if (mrun) begin
                if (fe && mq.size() < DEPTH) begin
                    mq.push_back({mpc, mem_fn(mpc)});
                    mpc = mpc + 32'd4;
                end
            end else if (fe) begin
                mrun = 1'b1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive at the falling edge, apply one rising edge, land on the next falling edge.
    task automatic step(input logic r, input logic fe, input logic red,
                        input logic [31:0] rp, input logic rdy);
        rst         = r;
        fetch_en    = fe;
        redirect    = red;
        redirect_pc = rp;
        inst_ready  = rdy;
        @(posedge clk);
        model_edge(r, fe, red, rp, rdy);
        @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ew;
        ev  = (mq.size() != 0);
        epc = ev ? mq[0][63:32] : 32'd0;
        ew  = ev ? mq[0][31:0] : 32'd0;
        chk({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, ev});
        chk({tag, ".pc"}, inst_pc, epc);
        chk({tag, ".inst"}, inst, ew);
        chk({tag, ".addr"}, imem_addr, mpc);
        chk({tag, ".count"}, fetch_count, mfc);
    endtask

    typedef struct {
        logic        rst;
        logic        fe;
        logic        red;
        logic [31:0] rp;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic [31:0] ecnt;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic fe, input logic red, input logic [31:0] rp,
                       input logic rdy, input logic ev, input logic [31:0] epc,
                       input logic [31:0] eaddr, input logic [31:0] ecnt);
        vec_t v;
        v.rst = r; v.fe = fe; v.red = red; v.rp = rp; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.ecnt = ecnt;
        vt.push_back(v);
    endtask

    initial begin
        vec_t        v;
        int          k;
        rst         = 1'b1;
        fetch_en    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        inst_ready  = 1'b0;
        mpc         = RST_PC;
        mrun        = 1'b0;
        mfc         = 32'd0;

        //   rst fe red rp            rdy  ev pc            addr          cnt
        add(1, 1, 1, 32'h40,        1, 0, 32'h0,        32'h0,        0);
        add(0, 1, 0, 32'h0,         1, 0, 32'h0,        32'h0,        0);
        add(0, 1, 0, 32'h0,         1, 1, 32'h0,        32'h4,        0);
        add(0, 1, 0, 32'h0,         1, 1, 32'h4,        32'h8,        1);
        add(0, 1, 0, 32'h0,         1, 1, 32'h8,        32'hC,        2);
        add(0, 1, 0, 32'h0,         0, 1, 32'h8,        32'h10,       2);
        add(0, 1, 0, 32'h0,         0, 1, 32'h8,        32'h10,       2);
        add(0, 1, 0, 32'h0,         0, 1, 32'h8,        32'h10,       2);
        add(0, 1, 0, 32'h0,         1, 1, 32'hC,        32'h14,       3);
        add(0, 0, 0, 32'h0,         1, 1, 32'h10,       32'h14,       4);
        add(0, 0, 0, 32'h0,         1, 0, 32'h0,        32'h14,       5);
        add(0, 1, 0, 32'h0,         0, 1, 32'h14,       32'h18,       5);
        add(0, 1, 0, 32'h0,         0, 1, 32'h14,       32'h1C,       5);
        add(0, 1, 1, 32'h103,       1, 0, 32'h0,        32'h100,      6);
        add(0, 1, 0, 32'h0,         1, 1, 32'h100,      32'h104,      6);
        add(0, 1, 1, 32'hFFFF_FFF8, 0, 0, 32'h0,        32'hFFFF_FFF8, 6);
        add(0, 1, 0, 32'h0,         1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 6);
        add(0, 1, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 32'h0,        7);
        add(0, 1, 0, 32'h0,         1, 1, 32'h0,        32'h4,        8);
        add(0, 1, 0, 32'h0,         0, 1, 32'h0,        32'h8,        8);
        add(1, 1, 1, 32'h200,       1, 0, 32'h0,        RST_PC,       0);
        add(0, 0, 0, 32'h0,         1, 0, 32'h0,        RST_PC,       0);
        add(0, 0, 0, 32'h0,         1, 0, 32'h0,        RST_PC,       0);
        add(0, 1, 0, 32'h0,         1, 0, 32'h0,        RST_PC,       0);
        add(0, 1, 0, 32'h0,         1, 1, RST_PC,       RST_PC + 4,   0);

        @(negedge clk);
        foreach (vt[i]) begin
            v = vt[i];
            step(v.rst, v.fe, v.red, v.rp, v.rdy);
            chk($sformatf("vec%0d.valid", i), {31'd0, inst_valid}, {31'd0, v.ev});
            chk($sformatf("vec%0d.pc", i), inst_pc, v.epc);
            chk($sformatf("vec%0d.inst", i), inst, v.ev ? mem_fn(v.epc) : 32'd0);
            chk($sformatf("vec%0d.addr", i), imem_addr, v.eaddr);
            chk($sformatf("vec%0d.count", i), fetch_count, v.ecnt);
        end

        // Randomized traffic, including occasional redirects and resets.
        for (int c = 0; c < 600; c++) begin
            step(($urandom % 97) == 0, ($urandom % 8) != 0, ($urandom % 16) == 0,
                 $urandom, ($urandom % 3) != 0);
            chk_model("rand");
        end

        // Ten deliveries under random backpressure.
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk_model("d10rst");
        k = 0;
        while (mfc < 32'd10 && k < 300) begin
            step(1'b0, 1'b1, 1'b0, 32'd0, $urandom_range(0, 1) == 1);
            chk_model("d10");
            k++;
        end
        chk("d10.timeout", {31'd0, k >= 300}, 32'd0);
        chk("d10.fetch_count", fetch_count, 32'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the byte address of the first fetch after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the number of prefetch queue entries (power of two, 2..8).
REQ-003 Port clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1, is the reset: synchronous, active-high.
REQ-005 Port fetch_en, input, 1, SHALL mean fetching is permitted.
REQ-006 Port imem_addr, output, 32, SHALL carry the byte address presented to instruction memory.
REQ-007 Port imem_data, input, 32, SHALL carry the big-endian instruction word at imem_addr, valid combinationally in the same cycle.
REQ-008 Port redirect, input, 1, SHALL signal a branch or jump redirect.
REQ-009 Port redirect_pc, input, 32, SHALL carry the redirect target byte address.
REQ-010 Port inst_valid, output, 1, SHALL mean a queued instruction is available.
REQ-011 Port inst_ready, input, 1, SHALL mean the decode stage accepts the instruction.
REQ-012 Port inst, output, 32, SHALL carry the head-of-queue instruction word.
REQ-013 Port inst_pc, output, 32, SHALL carry the head-of-queue instruction byte address.
REQ-014 Port fetch_count, output, 32, SHALL count instructions delivered to decode.

Function
REQ-015 The FSM SHALL have exactly the states IDLE and RUN; reset enters IDLE.
REQ-016 In IDLE, no queue push SHALL occur; IDLE SHALL go to RUN on the first cycle fetch_en=1.
REQ-017 In RUN, fetch_en=0 SHALL suppress pushes without changing state; the queue SHALL still drain.
REQ-018 imem_addr SHALL equal the fetch_pc register at all times.
REQ-019 Push condition: RUN and fetch_en and not redirect and (count<DEPTH or a pop occurs this cycle).
REQ-020 A push SHALL store {fetch_pc, imem_data} at the queue tail and advance fetch_pc by 4 with 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-021 A pop SHALL occur when inst_valid and inst_ready are both 1; it SHALL increment fetch_count, which wraps modulo 2^32.
REQ-022 inst_valid SHALL equal (count!=0); inst and inst_pc SHALL be the head entry, and SHALL be 0 when the queue is empty.
REQ-023 Simultaneous push and pop on a full queue SHALL leave count at DEPTH with no data loss.
REQ-024 Redirect SHALL have priority over everything: flush the queue (count=0), set fetch_pc to {redirect_pc[31:2],2'b00}, and enter RUN from either state.
REQ-025 Fetch latency SHALL be one cycle: an instruction pushed at edge N is visible on inst at N+1.
REQ-026 Redirect latency: the redirect target instruction SHALL appear on inst two edges after redirect is sampled, if fetch_en=1 and inst_ready=1.
REQ-027 A pop handshake in a redirect cycle SHALL still count in fetch_count; the popped entry is consumed.

Reset
REQ-028 Reset SHALL set state=IDLE, fetch_pc=RESET_PC, count=0, the head/tail pointers to 0, and fetch_count=0.
REQ-029 Reset SHALL dominate redirect and fetch_en in the same cycle; reset mid-stream SHALL discard all queued entries.
REQ-030 During and after reset: inst_valid=0, inst=0, inst_pc=0, imem_addr=RESET_PC.

Structure
REQ-031 Package imem_fetch_pkg SHALL hold the state enum, the queue entry struct {pc, word}, and the default RESET_PC constant.
REQ-032 The queue SHALL be a sub-module fetch_fifo (synchronous, parameterised DEPTH, with flush input); the FSM and PC logic stay in imem_fetch_ctrl.

Verification
REQ-033 Reset, fetch_en=1, inst_ready=1, sequential memory -> inst_pc 0,4,8,... on consecutive cycles starting one cycle after RUN is entered.
REQ-034 inst_ready=0 for 5 cycles -> queue fills to DEPTH=2, imem_addr holds 8, no push; ready=1 -> inst_pc 0,4,8 in order, no gaps or duplicates.
REQ-035 Redirect with redirect_pc=32'h0000_0103 while queue is full -> next cycle inst_valid=0 and imem_addr=32'h100; the following cycle inst_pc=32'h100.
REQ-036 Redirect to 32'hFFFF_FFF8, run 3 fetches -> inst_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 Assert rst mid-stream with queue occupied and redirect=1 -> next cycle state IDLE, inst_valid=0, imem_addr=RESET_PC, fetch_count=0.
REQ-038 Deliver 10 instructions with random inst_ready -> fetch_count=10, and every inst matches the memory model at inst_pc.
